// File: rtl/corr_pixel_server_pkg.sv
// Shared widths and capture-state encoding for the
// correlator pixel server.
package corr_pixel_server_pkg;

  localparam int PIX_W   = 10;
  localparam int COORD_W = 13;
  localparam int SRAM_AW = 20;
  localparam int DQ_W    = 16;

  typedef enum logic [1:0] {
    CAP_IDLE    = 2'd0,
    CAP_ARMED   = 2'd1,
    CAP_CAPTURE = 2'd2,
    CAP_READY   = 2'd3
  } cap_state_e;

endpackage

// File: rtl/corr_tpl_ram.sv
// Template buffer: simple dual-port RAM, synchronous
// read, read-before-write on address collision.
module corr_tpl_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10,
  parameter int DW    = 10
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  // Capture write port and registered scorer read port
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/corr_pixel_server.sv
// Pixel responder for the correlation scorer: frame
// pixels from SRAM, template pixels from a captured window.
module corr_pixel_server
  import corr_pixel_server_pkg::*;
#(
  parameter int FRAME_W  = 640,
  parameter int FRAME_H  = 480,
  parameter int TPL_W    = 32,
  parameter int TPL_H    = 32,
  parameter int TPL_X0   = 304,
  parameter int TPL_Y0   = 224,
  parameter int SRAM_LAT = 1
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic [COORD_W-1:0] iX_sram,
  input  logic [COORD_W-1:0] iY_sram,
  input  logic [COORD_W-1:0] iX_search,
  input  logic [COORD_W-1:0] iY_search,
  output logic [PIX_W-1:0]   oReading_sram,
  output logic [PIX_W-1:0]   oReading_search,
  output logic [SRAM_AW-1:0] oSRAM_ADDR,
  output logic               oSRAM_OE_N,
  input  logic [DQ_W-1:0]    iSRAM_DQ,
  input  logic               iCapture,
  input  logic               iFVAL,
  input  logic               iDVAL,
  input  logic [COORD_W-1:0] iStreamX,
  input  logic [COORD_W-1:0] iStreamY,
  input  logic [PIX_W-1:0]   iPixel,
  output logic               oTplReady
);

  localparam int TD   = TPL_W * TPL_H;
  localparam int TA_W = $clog2(TD);

  // ---- frame read path ----
  logic               sram_rng_d;
  logic [SRAM_AW-1:0] sram_addr_d;
  logic [SRAM_AW-1:0] sram_addr_q;
  logic               oe_n_q;
  logic               rng_q [SRAM_LAT+1];
  logic [PIX_W-1:0]   rd_sram_q;

  assign sram_rng_d =
    (iX_sram < COORD_W'(FRAME_W)) &&
    (iY_sram < COORD_W'(FRAME_H));

  assign sram_addr_d =
    SRAM_AW'(iY_sram) * SRAM_AW'(FRAME_W) +
    SRAM_AW'(iX_sram);

  // Address stage; range flag follows the slot to the output
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      sram_addr_q <= '0;
      oe_n_q      <= 1'b1;
      for (int i = 0; i <= SRAM_LAT; i++) begin
        rng_q[i] <= 1'b0;
      end
    end else begin
      sram_addr_q <= sram_rng_d ? sram_addr_d : '0;
      oe_n_q      <= ~sram_rng_d;
      rng_q[0]    <= sram_rng_d;
      for (int i = 1; i <= SRAM_LAT; i++) begin
        rng_q[i] <= rng_q[i-1];
      end
    end
  end

  // ---- template read path ----
  cap_state_e        state_q;
  cap_state_e        state_d;
  logic              tpl_ready;
  logic              tpl_ok_d;
  logic [TA_W-1:0]   tpl_raddr_d;
  logic [TA_W-1:0]   tpl_raddr_q [SRAM_LAT];
  logic              tpl_ok_q [SRAM_LAT];
  logic              tpl_ok_rd_q;
  logic [PIX_W-1:0]  tpl_rdata;
  logic [PIX_W-1:0]  rd_search_q;

  assign tpl_ready = (state_q == CAP_READY);

  assign tpl_ok_d =
    (iX_search < COORD_W'(TPL_W)) &&
    (iY_search < COORD_W'(TPL_H)) && tpl_ready;

  assign tpl_raddr_d =
    TA_W'(iY_search) * TA_W'(TPL_W) +
    TA_W'(iX_search);

  // Delay template reads so the RAM lands with SRAM data
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      for (int i = 0; i < SRAM_LAT; i++) begin
        tpl_raddr_q[i] <= '0;
        tpl_ok_q[i]    <= 1'b0;
      end
      tpl_ok_rd_q <= 1'b0;
    end else begin
      tpl_raddr_q[0] <= tpl_ok_d ? tpl_raddr_d : '0;
      tpl_ok_q[0]    <= tpl_ok_d;
      for (int i = 1; i < SRAM_LAT; i++) begin
        tpl_raddr_q[i] <= tpl_raddr_q[i-1];
        tpl_ok_q[i]    <= tpl_ok_q[i-1];
      end
      tpl_ok_rd_q <= tpl_ok_q[SRAM_LAT-1];
    end
  end

  // Output registers; invalid slots return zero
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      rd_sram_q   <= '0;
      rd_search_q <= '0;
    end else begin
      rd_sram_q <= rng_q[SRAM_LAT] ?
                   iSRAM_DQ[PIX_W-1:0] : '0;
      rd_search_q <= tpl_ok_rd_q ? tpl_rdata : '0;
    end
  end

  // ---- template capture ----
  logic               fval_q;
  logic               fval_rise;
  logic               in_win;
  logic               last_px;
  logic               tpl_we;
  logic [COORD_W-1:0] wr_dx;
  logic [COORD_W-1:0] wr_dy;
  logic [TA_W-1:0]    tpl_waddr;

  assign fval_rise = iFVAL & ~fval_q;

  assign in_win = iDVAL &&
    (iStreamX >= COORD_W'(TPL_X0)) &&
    (iStreamX <  COORD_W'(TPL_X0 + TPL_W)) &&
    (iStreamY >= COORD_W'(TPL_Y0)) &&
    (iStreamY <  COORD_W'(TPL_Y0 + TPL_H));

  assign last_px =
    (iStreamX == COORD_W'(TPL_X0 + TPL_W - 1)) &&
    (iStreamY == COORD_W'(TPL_Y0 + TPL_H - 1));

  assign tpl_we = (state_q == CAP_CAPTURE) && in_win;

  assign wr_dx = iStreamX - COORD_W'(TPL_X0);
  assign wr_dy = iStreamY - COORD_W'(TPL_Y0);

  assign tpl_waddr =
    TA_W'(wr_dy) * TA_W'(TPL_W) + TA_W'(wr_dx);

  // Capture state and frame-valid edge history
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q <= CAP_IDLE;
      fval_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fval_q  <= iFVAL;
    end
  end

  // Capture next state; an aborted frame re-arms
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      CAP_IDLE: begin
        if (iCapture) state_d = CAP_ARMED;
      end
      CAP_ARMED: begin
        if (fval_rise) state_d = CAP_CAPTURE;
      end
      CAP_CAPTURE: begin
        if (tpl_we && last_px) state_d = CAP_READY;
        else if (!iFVAL)       state_d = CAP_ARMED;
      end
      CAP_READY: begin
        if (iCapture) state_d = CAP_ARMED;
      end
      default: state_d = CAP_IDLE;
    endcase
  end

  corr_tpl_ram #(
    .DEPTH (TD),
    .AW    (TA_W),
    .DW    (PIX_W)
  ) u_tpl_ram (
    .clk_i   (iCLK),
    .we_i    (tpl_we),
    .waddr_i (tpl_waddr),
    .wdata_i (iPixel),
    .raddr_i (tpl_raddr_q[SRAM_LAT-1]),
    .rdata_o (tpl_rdata)
  );

  logic unused_dq;
  assign unused_dq = ^iSRAM_DQ[DQ_W-1:PIX_W];

  assign oReading_sram   = rd_sram_q;
  assign oReading_search = rd_search_q;
  assign oSRAM_ADDR      = sram_addr_q;
  assign oSRAM_OE_N      = oe_n_q;
  assign oTplReady       = tpl_ready;

endmodule

// File: tb/tb_corr_pixel_server.sv
// Scoreboard bench for corr_pixel_server: directed
// reads, template capture, aborted frame, reset.
module tb_corr_pixel_server;

  localparam int RL = 3;

  logic        clk = 1'b0;
  logic        iRST;
  logic [12:0] iX_sram, iY_sram;
  logic [12:0] iX_search, iY_search;
  logic [9:0]  oReading_sram, oReading_search;
  logic [19:0] oSRAM_ADDR;
  logic        oSRAM_OE_N;
  logic [15:0] sram_dq = 16'h0;
  logic        iCapture, iFVAL, iDVAL;
  logic [12:0] iStreamX, iStreamY;
  logic [9:0]  iPixel;
  logic        oTplReady;

  int n_pass = 0;
  int n_total = 0;

  typedef struct { int addr; int oe_n; } aexp_t;
  typedef struct { int pix; int srch; } dexp_t;
  aexp_t aq[$];
  dexp_t dq[$];

  logic          issue = 1'b0;
  logic [RL-1:0] vpipe = '0;

  corr_pixel_server dut (
    .iCLK            (clk),
    .iRST            (iRST),
    .iX_sram         (iX_sram),
    .iY_sram         (iY_sram),
    .iX_search       (iX_search),
    .iY_search       (iY_search),
    .oReading_sram   (oReading_sram),
    .oReading_search (oReading_search),
    .oSRAM_ADDR      (oSRAM_ADDR),
    .oSRAM_OE_N      (oSRAM_OE_N),
    .iSRAM_DQ        (sram_dq),
    .iCapture        (iCapture),
    .iFVAL           (iFVAL),
    .iDVAL           (iDVAL),
    .iStreamX        (iStreamX),
    .iStreamY        (iStreamY),
    .iPixel          (iPixel),
    .oTplReady       (oTplReady)
  );

  always #5 clk = ~clk;

  // SRAM model, one cycle latency; garbage when not enabled
  always @(posedge clk)
    sram_dq <= oSRAM_OE_N ? 16'hFFFF :
               {6'd0, oSRAM_ADDR[9:0]};

  always @(posedge clk)
    vpipe <= {vpipe[RL-2:0], issue};

  task automatic chk(input string nm,
                     input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d",
                  nm, got, exp);
  endtask

  // Monitor: pops expectations as tagged slots emerge
  always @(negedge clk) begin
    aexp_t a;
    dexp_t d;
    if (vpipe[0]) begin
      if (aq.size() == 0) chk("addr_underflow", 0, 1);
      else begin
        a = aq.pop_front();
        chk("oe_n", int'(oSRAM_OE_N), a.oe_n);
        if (a.oe_n == 0)
          chk("sram_addr", int'(oSRAM_ADDR), a.addr);
      end
    end
    if (vpipe[RL-1]) begin
      if (dq.size() == 0) chk("data_underflow", 0, 1);
      else begin
        d = dq.pop_front();
        chk("rd_sram", int'(oReading_sram), d.pix);
        chk("rd_search", int'(oReading_search), d.srch);
      end
    end
  end

  task automatic idle_req();
    issue = 1'b0;
    iX_sram = 13'h1FFF; iY_sram = 13'h1FFF;
    iX_search = 13'h1FFF; iY_search = 13'h1FFF;
  endtask

  task automatic rd(input int x, input int y,
                    input int sx, input int sy,
                    input int addr, input int oe_n,
                    input int pix, input int srch);
    aexp_t a;
    dexp_t d;
    iX_sram = 13'(x); iY_sram = 13'(y);
    iX_search = 13'(sx); iY_search = 13'(sy);
    issue = 1'b1;
    a.addr = addr; a.oe_n = oe_n;
    d.pix = pix; d.srch = srch;
    aq.push_back(a);
    dq.push_back(d);
    @(negedge clk);
  endtask

  task automatic drain();
    idle_req();
    repeat (RL + 2) @(negedge clk);
    chk("drain", aq.size() + dq.size(), 0);
  endtask

  // Reduced frame around the template window
  task automatic frame(input int stop_row,
                       input bit do_rst,
                       input bit chk_rise);
    iFVAL = 1'b0; iDVAL = 1'b0;
    repeat (3) @(negedge clk);
    iFVAL = 1'b1;
    @(negedge clk);
    for (int y = 222; y <= 257; y++) begin
      if (y == stop_row) begin
        if (do_rst) begin
          iRST = 1'b1;
          @(negedge clk);
          iRST = 1'b0;
        end
        iFVAL = 1'b0; iDVAL = 1'b0;
        @(negedge clk);
        return;
      end
      for (int x = 302; x <= 337; x++) begin
        iDVAL = 1'b1;
        iStreamX = 13'(x); iStreamY = 13'(y);
        iPixel = 10'((x + y) & 'h3FF);
        if (chk_rise && x == 335 && y == 255)
          chk("rdy_pre", int'(oTplReady), 0);
        @(negedge clk);
        if (chk_rise && x == 335 && y == 255)
          chk("rdy_rise", int'(oTplReady), 1);
      end
      iDVAL = 1'b0;
      @(negedge clk);
    end
    iFVAL = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    iRST = 1'b1;
    iCapture = 1'b0; iFVAL = 1'b0; iDVAL = 1'b0;
    iStreamX = '0; iStreamY = '0; iPixel = '0;
    idle_req();
    repeat (3) @(negedge clk);
    chk("rst_rd_sram", int'(oReading_sram), 0);
    chk("rst_rd_search", int'(oReading_search), 0);
    chk("rst_addr", int'(oSRAM_ADDR), 0);
    chk("rst_oe_n", int'(oSRAM_OE_N), 1);
    chk("rst_rdy", int'(oTplReady), 0);
    iRST = 1'b0;
    @(negedge clk);

    // back-to-back frame reads, template not ready
    rd(5, 2, 0, 0, 1285, 0, 261, 0);
    rd(0, 0, 0, 0, 0, 0, 0, 0);
    rd(639, 479, 1, 1, 307199, 0, 1023, 0);
    rd(640, 0, 0, 0, 0, 1, 0, 0);
    rd(0, 480, 0, 0, 0, 1, 0, 0);
    rd(100, 10, 0, 0, 6500, 0, 356, 0);
    drain();

    // arm, abort at template row 10, then full frame
    iCapture = 1'b1;
    @(negedge clk);
    iCapture = 1'b0;
    frame(234, 1'b0, 1'b0);
    chk("rdy_abort", int'(oTplReady), 0);
    frame(9999, 1'b0, 1'b1);
    chk("rdy_full", int'(oTplReady), 1);

    // template reads mixed with frame reads
    rd(1, 1, 0, 0, 641, 0, 641, 528);
    rd(639, 0, 31, 31, 639, 0, 639, 590);
    rd(0, 479, 5, 3, 306560, 0, 384, 536);
    rd(640, 479, 32, 0, 0, 1, 0, 0);
    rd(5, 2, 0, 32, 1285, 0, 261, 0);
    rd(5, 2, 10, 20, 1285, 0, 261, 558);
    drain();

    // re-arm clears ready, then reset mid-capture
    iCapture = 1'b1;
    @(negedge clk);
    iCapture = 1'b0;
    chk("rdy_clr", int'(oTplReady), 0);
    frame(230, 1'b1, 1'b0);
    chk("rdy_rst", int'(oTplReady), 0);
    rd(0, 0, 0, 0, 0, 0, 0, 0);
    rd(5, 2, 31, 31, 1285, 0, 261, 0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
